cs_address_sequencer: RTL and testbench



---
 rtl/cs_sequencer_pkg.sv | 30 +++
 rtl/cs_branch_select.sv | 41 ++++
 rtl/cs_address_sequencer.sv | 91 +++++++++
 tb/tb_cs_address_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_sequencer_pkg.sv
// Shared encodings for the ARC control-store address sequencer:
// microword condition codes, sequencer states and fixed control-store addresses.
package cs_sequencer_pkg;

  localparam int CS_ADDR_W = 11;
  localparam int COND_W    = 3;

  localparam logic [COND_W-1:0] COND_NEXT   = 3'b000;
  localparam logic [COND_W-1:0] COND_N      = 3'b001;
  localparam logic [COND_W-1:0] COND_Z      = 3'b010;
  localparam logic [COND_W-1:0] COND_V      = 3'b011;
  localparam logic [COND_W-1:0] COND_C      = 3'b100;
  localparam logic [COND_W-1:0] COND_IR13   = 3'b101;
  localparam logic [COND_W-1:0] COND_JUMP   = 3'b110;
  localparam logic [COND_W-1:0] COND_DECODE = 3'b111;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

  localparam logic [CS_ADDR_W-1:0] CS_FETCH  = 11'd0;
  localparam logic [CS_ADDR_W-1:0] CS_DECODE = 11'd1;

  // Decode entry point: op and op3 select a 4-word slot in the upper half of the store.
  function automatic logic [CS_ADDR_W-1:0] decode_addr(input logic [31:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/cs_branch_select.sv
// Combinational next-address mux: CSAR+1, microword jump target, or IR decode address.
module cs_branch_select
  import cs_sequencer_pkg::*;
#(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32
) (
  input  logic [DATAWIDTH_CONDITION-1:0]   condition,
  input  logic                             flag_n,
  input  logic                             flag_z,
  input  logic                             flag_v,
  input  logic                             flag_c,
  input  logic [DATAWIDTH_IR-1:0]          ir,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] jump_address,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] csar,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] next_address
);

  localparam logic [DATAWIDTH_JUMPADDRESS-1:0] ADDR_ONE = 1;

  logic take_jump;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    take_jump    = 1'b0;
    next_address = csar + ADDR_ONE;
    unique case (condition)
      COND_N:    take_jump = flag_n;
      COND_Z:    take_jump = flag_z;
      COND_V:    take_jump = flag_v;
      COND_C:    take_jump = flag_c;
      COND_IR13: take_jump = ir[13];
      COND_JUMP: take_jump = 1'b1;
      COND_DECODE: next_address = decode_addr(ir);
      default:   take_jump = 1'b0;
    endcase
    if (take_jump) next_address = jump_address;
  end

endmodule

// File: rtl/cs_address_sequencer.sv
// ARC micro-sequencer: owns the CSAR, selects the next microaddress each cycle and
// holds the microprogram while a main-memory access is outstanding.
module cs_address_sequencer
  import cs_sequencer_pkg::*;
#(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32
) (
  input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic                             CS_ADDRESS_SEQUENCER_ResetInHigh_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_RD_In,
  input  logic                             CS_ADDRESS_SEQUENCER_WR_In,
  input  logic                             CS_ADDRESS_SEQUENCER_MemDone_In,
  input  logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_FlagN_In,
  input  logic                             CS_ADDRESS_SEQUENCER_FlagZ_In,
  input  logic                             CS_ADDRESS_SEQUENCER_FlagV_In,
  input  logic                             CS_ADDRESS_SEQUENCER_FlagC_In,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
  output logic                             CS_ADDRESS_SEQUENCER_Stall_Out
);

  state_e                           state_q, state_d;
  logic [DATAWIDTH_JUMPADDRESS-1:0] csar_q, csar_d;
  logic [DATAWIDTH_JUMPADDRESS-1:0] next_address;
  logic                             mem_req;
  logic                             stall;

  cs_branch_select #(
    .DATAWIDTH_JUMPADDRESS(DATAWIDTH_JUMPADDRESS),
    .DATAWIDTH_CONDITION  (DATAWIDTH_CONDITION),
    .DATAWIDTH_IR         (DATAWIDTH_IR)
  ) u_branch_select (
    .condition   (CS_ADDRESS_SEQUENCER_Condition_InBus),
    .flag_n      (CS_ADDRESS_SEQUENCER_FlagN_In),
    .flag_z      (CS_ADDRESS_SEQUENCER_FlagZ_In),
    .flag_v      (CS_ADDRESS_SEQUENCER_FlagV_In),
    .flag_c      (CS_ADDRESS_SEQUENCER_FlagC_In),
    .ir          (CS_ADDRESS_SEQUENCER_IR_InBus),
    .jump_address(CS_ADDRESS_SEQUENCER_JumpAddress_InBus),
    .csar        (csar_q),
    .next_address(next_address)
  );

  assign mem_req = CS_ADDRESS_SEQUENCER_RD_In | CS_ADDRESS_SEQUENCER_WR_In;

  always_comb begin
    state_d = state_q;
    csar_d  = csar_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !CS_ADDRESS_SEQUENCER_MemDone_In) begin
          state_d = ST_MEMWAIT;
          stall   = 1'b1;
        end else begin
          csar_d = next_address;
        end
      end
      ST_MEMWAIT: begin
        // The request may be dropped while waiting; only completion releases the hold.
        if (CS_ADDRESS_SEQUENCER_MemDone_In) begin
          csar_d  = next_address;
          state_d = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
    if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
      state_q <= ST_RUN;
      csar_q  <= CS_FETCH;
    end else begin
      state_q <= state_d;
      csar_q  <= csar_d;
    end
  end

  assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = csar_q;
  // Reset overrides any pending access, so no stall is reported while it is held.
  assign CS_ADDRESS_SEQUENCER_Stall_Out = stall & ~CS_ADDRESS_SEQUENCER_ResetInHigh_In;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed self-checking bench for cs_address_sequencer: reset, decode, flag branches,
// memory stall, reset during a wait and address wrap.
module tb_cs_address_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic        rd, wr, done;
  logic [31:0] ir;
  logic        fn, fz, fv, fc;
  logic [10:0] csar;
  logic        stall;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] C_NEXT = 3'b000;
  localparam logic [2:0] C_IR13 = 3'b101;
  localparam logic [2:0] C_JUMP = 3'b110;
  localparam logic [2:0] C_DEC  = 3'b111;

  cs_address_sequencer dut (
    .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
    .CS_ADDRESS_SEQUENCER_ResetInHigh_In   (rst),
    .CS_ADDRESS_SEQUENCER_Condition_InBus  (cond),
    .CS_ADDRESS_SEQUENCER_JumpAddress_InBus(jump),
    .CS_ADDRESS_SEQUENCER_RD_In            (rd),
    .CS_ADDRESS_SEQUENCER_WR_In            (wr),
    .CS_ADDRESS_SEQUENCER_MemDone_In       (done),
    .CS_ADDRESS_SEQUENCER_IR_InBus         (ir),
    .CS_ADDRESS_SEQUENCER_FlagN_In         (fn),
    .CS_ADDRESS_SEQUENCER_FlagZ_In         (fz),
    .CS_ADDRESS_SEQUENCER_FlagV_In         (fv),
    .CS_ADDRESS_SEQUENCER_FlagC_In         (fc),
    .CS_ADDRESS_SEQUENCER_CSAddress_OutBus (csar),
    .CS_ADDRESS_SEQUENCER_Stall_Out        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic drive(input logic [2:0] c, input logic [10:0] j,
                       input logic rd_v, input logic wr_v, input logic done_v,
                       input logic [3:0] nzvc);
    @(negedge clk);
    cond = c; jump = j; rd = rd_v; wr = wr_v; done = done_v;
    {fn, fz, fv, fc} = nzvc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_addr(input logic [10:0] a);
    drive(C_JUMP, a, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checks++;
    if (csar !== a) begin
      errors++;
      $display("FAIL goto_addr: csar=%0d expected=%0d", csar, a);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cond = 3'($urandom); jump = 11'($urandom); ir = $urandom;
      rd = 1'($urandom); wr = 1'($urandom); done = 1'($urandom);
      {fn, fz, fv, fc} = 4'($urandom);
      tick();
      checks++;
      if (csar !== 11'd0) begin
        errors++;
        $display("FAIL reset_csar cycle %0d: csar=%0d expected=0", i, csar);
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall cycle %0d: stall=%b expected=0", i, stall);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    cond = C_NEXT; rd = 1'b0; wr = 1'b0; done = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (csar !== 11'(i)) begin
        errors++;
        $display("FAIL reset_release_incr: csar=%0d expected=%0d", csar, i);
      end
    end
  endtask

  task automatic test_decode();
    goto_addr(11'd1);
    ir = 32'h8080_0000;
    drive(C_DEC, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd1600) begin
      errors++;
      $display("FAIL decode_addcc: csar=%0d expected=1600", csar);
    end
    ir = 32'h8080_2000;
    drive(C_IR13, 11'd1602, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd1602) begin
      errors++;
      $display("FAIL ir13_taken: csar=%0d expected=1602", csar);
    end
    goto_addr(11'd1600);
    ir = 32'h8080_0000;
    drive(C_IR13, 11'd1602, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    checks++;
    if (csar !== 11'd1601) begin
      errors++;
      $display("FAIL ir13_not_taken: csar=%0d expected=1601", csar);
    end
  endtask

  task automatic test_flags();
    logic [3:0] sel;
    for (int k = 1; k <= 4; k++) begin
      sel = 4'b1000 >> (k - 1);
      // Only the matching flag set: must jump.
      drive(3'(k), 11'h155, 1'b0, 1'b0, 1'b0, sel);
      tick();
      checks++;
      if (csar !== 11'h155) begin
        errors++;
        $display("FAIL flag_taken cond=%0d: csar=%h expected=155", k, csar);
      end
      // All other flags set: must fall through to CSAR+1.
      drive(3'(k), 11'h155, 1'b0, 1'b0, 1'b0, ~sel);
      tick();
      checks++;
      if (csar !== 11'h156) begin
        errors++;
        $display("FAIL flag_not_taken cond=%0d: csar=%h expected=156", k, csar);
      end
    end
    drive(C_JUMP, 11'h155, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'h155) begin
      errors++;
      $display("FAIL jump_flags0: csar=%h expected=155", csar);
    end
    drive(C_NEXT, 11'h3AA, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    checks++;
    if (csar !== 11'h156) begin
      errors++;
      $display("FAIL next_flags1: csar=%h expected=156", csar);
    end
    drive(C_JUMP, 11'h155, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    checks++;
    if (csar !== 11'h155) begin
      errors++;
      $display("FAIL jump_flags1: csar=%h expected=155", csar);
    end
  endtask

  task automatic test_mem_stall();
    goto_addr(11'd0);
    // Three wait cycles; request dropped and condition changed mid-wait.
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive(C_NEXT, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
      else if (i == 2) drive(C_JUMP, 11'h155, 1'b1, 1'b0, 1'b0, 4'b0000);
      else drive(C_NEXT, 11'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_wait%0d: stall=%b expected=1", i, stall);
      end
      tick();
      checks++;
      if (csar !== 11'd0) begin
        errors++;
        $display("FAIL hold_wait%0d: csar=%0d expected=0", i, csar);
      end
    end
    drive(C_NEXT, 11'd0, 1'b1, 1'b0, 1'b1, 4'b0000);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: stall=%b expected=0", stall);
    end
    tick();
    checks++;
    if (csar !== 11'd1) begin
      errors++;
      $display("FAIL advance_done: csar=%0d expected=1", csar);
    end
  endtask

  task automatic test_back_to_back();
    // Zero-wait read, then read+write, then done with no request.
    drive(C_NEXT, 11'd0, 1'b1, 1'b0, 1'b1, 4'b0000);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait_stall: stall=%b expected=0", stall);
    end
    tick();
    checks++;
    if (csar !== 11'd2) begin
      errors++;
      $display("FAIL zero_wait_rd: csar=%0d expected=2", csar);
    end
    drive(C_NEXT, 11'd0, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd3) begin
      errors++;
      $display("FAIL zero_wait_rdwr: csar=%0d expected=3", csar);
    end
    drive(C_NEXT, 11'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd4) begin
      errors++;
      $display("FAIL done_no_req: csar=%0d expected=4", csar);
    end
    drive(C_NEXT, 11'd0, 1'b1, 1'b1, 1'b0, 4'b0000);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rdwr_stall: stall=%b expected=1", stall);
    end
    tick();
    checks++;
    if (csar !== 11'd4) begin
      errors++;
      $display("FAIL rdwr_hold: csar=%0d expected=4", csar);
    end
    drive(C_NEXT, 11'd0, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd5) begin
      errors++;
      $display("FAIL rdwr_release: csar=%0d expected=5", csar);
    end
  endtask

  task automatic test_reset_memwait();
    goto_addr(11'd5);
    drive(C_NEXT, 11'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd5) begin
      errors++;
      $display("FAIL wr_wait1: csar=%0d expected=5", csar);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (csar !== 11'd0) begin
      errors++;
      $display("FAIL reset_in_wait: csar=%0d expected=0", csar);
    end
    drive(C_NEXT, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_stall: stall=%b expected=0", stall);
    end
    tick();
    checks++;
    if (csar !== 11'd1) begin
      errors++;
      $display("FAIL reset_wait_run: csar=%0d expected=1", csar);
    end
  endtask

  task automatic test_wrap();
    goto_addr(11'd2047);
    drive(C_NEXT, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checks++;
    if (csar !== 11'd0) begin
      errors++;
      $display("FAIL wrap: csar=%0d expected=0", csar);
    end
  endtask

  initial begin
    rst = 1'b1; cond = C_NEXT; jump = 11'd0; ir = 32'd0;
    rd = 1'b0; wr = 1'b0; done = 1'b0;
    {fn, fz, fv, fc} = 4'b0000;
    test_reset();
    test_decode();
    test_flags();
    test_mem_stall();
    test_back_to_back();
    test_reset_memwait();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
